// File: rtl/lock_dispatch.sv
// ---------------------------------------------------------------------------
// lock_dispatch
//
// Upstream traffic stage for the canal-lock controller. Boats waiting on each
// side are counted in two saturating queues; the dispatcher alternates
// fairly between directions when both have traffic, raises the arrival
// request to the lock controller, holds the passage direction stable and
// faults if an accepted passage does not complete in time. One boat is in
// the lock at a time.
//
// Parameters
//   DEPTH        maximum boats waiting per direction
//   TIMEOUT      cycles allowed from lock_ack to passage_done
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   req_down     pulse: boat arrives for passage 1->3 (dir 0)
//   req_up       pulse: boat arrives for passage 3->1 (dir 1)
//   lock_ack     lock controller has accepted the boat
//   passage_done pulse: boat has left the lock
//   fault_clr    pulse: leave the fault state
//   arr_sw       arrival request to the lock controller
//   dir          direction of the current / last passage
//   q_down       boats waiting, dir 0
//   q_up         boats waiting, dir 1
//   overflow     sticky: a request arrived at a full queue
//   busy         a passage is being requested or is in progress
//   fault        passage timed out
// ---------------------------------------------------------------------------
module lock_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_down,
    input  logic                       req_up,
    input  logic                       lock_ack,
    input  logic                       passage_done,
    input  logic                       fault_clr,
    output logic                       arr_sw,
    output logic                       dir,
    output logic [$clog2(DEPTH+1)-1:0] q_down,
    output logic [$clog2(DEPTH+1)-1:0] q_up,
    output logic                       overflow,
    output logic                       busy,
    output logic                       fault
);

    localparam int QW = $clog2(DEPTH + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_TRANSIT,
        S_FAULT
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [TW-1:0]   timer;
    logic            last_served;
    logic            pick_dir;
    logic            accept;
    logic            timeout_hit;
    logic            deq_down;
    logic            deq_up;

    // Saturating queue update. A request and a dequeue in the same cycle
    // cancel; a request into a full queue is dropped (flagged elsewhere).
    function automatic logic [QW-1:0] queue_next(
        input logic [QW-1:0] cnt,
        input logic          inc,
        input logic          dec
    );
        logic [QW-1:0] res;
        res = cnt;
        if (inc && !dec && cnt != QW'(DEPTH)) begin
            res = cnt + QW'(1);
        end else if (dec && !inc) begin
            res = cnt - QW'(1);
        end
        return res;
    endfunction

    assign accept      = (state == S_REQ) && lock_ack;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));
    assign deq_down    = accept && !dir;
    assign deq_up      = accept && dir;

    // Fair pick: a lone nonempty queue wins outright; on a tie serve the
    // direction that was not served last.
    assign pick_dir = (q_down != '0 && q_up != '0) ? ~last_served : (q_up != '0);

    // NOTE: next_state gets its default before the case so every path
    // assigns it and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (q_down != '0 || q_up != '0) begin
                    next_state = S_REQ;
                end
            end
            S_REQ: begin
                if (lock_ack) begin
                    next_state = S_TRANSIT;
                end
            end
            S_TRANSIT: begin
                // passage_done wins over a timeout in the same cycle.
                if (passage_done) begin
                    next_state = S_IDLE;
                end else if (timeout_hit) begin
                    next_state = S_FAULT;
                end
            end
            S_FAULT: begin
                if (fault_clr) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Outputs are flopped from next_state so they line up with the state
    // register and carry no combinational path from the inputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arr_sw <= 1'b0;
            busy   <= 1'b0;
            fault  <= 1'b0;
        end else begin
            arr_sw <= (next_state == S_REQ);
            busy   <= (next_state == S_REQ) || (next_state == S_TRANSIT);
            fault  <= (next_state == S_FAULT);
        end
    end

    // Direction only changes when a new passage is chosen; it is held through
    // the passage, any fault and the following idle period.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dir         <= 1'b0;
            last_served <= 1'b1;
        end else if (state == S_IDLE && next_state == S_REQ) begin
            dir         <= pick_dir;
            last_served <= pick_dir;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (accept) begin
            timer <= '0;
        end else if (state == S_TRANSIT && !timeout_hit) begin
            timer <= timer + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_down   <= '0;
            q_up     <= '0;
            overflow <= 1'b0;
        end else begin
            q_down <= queue_next(q_down, req_down, deq_down);
            q_up   <= queue_next(q_up, req_up, deq_up);
            if ((req_down && !deq_down && q_down == QW'(DEPTH)) ||
                (req_up   && !deq_up   && q_up   == QW'(DEPTH))) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lock_dispatch.sv
// ---------------------------------------------------------------------------
// tb_lock_dispatch
//
// Self-checking bench for lock_dispatch (DEPTH=4, TIMEOUT=10). A behavioural
// model of the dispatcher (integer queue counts, a passage phase and a
// passage age counter) is stepped on every clock edge with the same inputs
// as the DUT, and all outputs are compared one time unit after the edge.
// Directed scenarios are followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_lock_dispatch;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 10;

    localparam int PH_IDLE    = 0;
    localparam int PH_REQ     = 1;
    localparam int PH_TRANSIT = 2;
    localparam int PH_FAULT   = 3;

    logic       clk;
    logic       reset;
    logic       req_down;
    logic       req_up;
    logic       lock_ack;
    logic       passage_done;
    logic       fault_clr;
    logic       arr_sw;
    logic       dir;
    logic [2:0] q_down;
    logic [2:0] q_up;
    logic       overflow;
    logic       busy;
    logic       fault;

    int n_checks;
    int n_fail;

    // Reference model state
    int m_qd;
    int m_qu;
    int m_ovf;
    int m_phase;
    int m_dir;
    int m_last;
    int m_age;

    int dispatch_log[$];

    lock_dispatch #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_down     (req_down),
        .req_up       (req_up),
        .lock_ack     (lock_ack),
        .passage_done (passage_done),
        .fault_clr    (fault_clr),
        .arr_sw       (arr_sw),
        .dir          (dir),
        .q_down       (q_down),
        .q_up         (q_up),
        .overflow     (overflow),
        .busy         (busy),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_qd    = 0;
        m_qu    = 0;
        m_ovf   = 0;
        m_phase = PH_IDLE;
        m_dir   = 0;
        m_last  = 1;
        m_age   = 0;
    endtask

    // One clock edge of the dispatcher, derived from the behavioural rules.
    task automatic model_step(input bit rd, input bit ru, input bit ack, input bit pd, input bit fc);
        bit take_d;
        bit take_u;
        take_d = (m_phase == PH_REQ) && ack && (m_dir == 0);
        take_u = (m_phase == PH_REQ) && ack && (m_dir == 1);

        case (m_phase)
            PH_IDLE: begin
                if (m_qd > 0 || m_qu > 0) begin
                    if (m_qd > 0 && m_qu > 0) m_dir = 1 - m_last;
                    else                      m_dir = (m_qu > 0) ? 1 : 0;
                    m_last  = m_dir;
                    m_phase = PH_REQ;
                end
            end
            PH_REQ: begin
                if (ack) begin
                    m_age   = 0;
                    m_phase = PH_TRANSIT;
                end
            end
            PH_TRANSIT: begin
                m_age++;
                if (pd)                    m_phase = PH_IDLE;
                else if (m_age >= TIMEOUT) m_phase = PH_FAULT;
            end
            default: begin
                if (fc) m_phase = PH_IDLE;
            end
        endcase

        if (rd && !take_d) begin
            if (m_qd == DEPTH) m_ovf = 1;
            else               m_qd++;
        end else if (take_d && !rd) begin
            m_qd--;
        end
        if (ru && !take_u) begin
            if (m_qu == DEPTH) m_ovf = 1;
            else               m_qu++;
        end else if (take_u && !ru) begin
            m_qu--;
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".arr_sw"},   arr_sw,   (m_phase == PH_REQ) ? 1 : 0);
        check({where, ".busy"},     busy,     (m_phase == PH_REQ || m_phase == PH_TRANSIT) ? 1 : 0);
        check({where, ".fault"},    fault,    (m_phase == PH_FAULT) ? 1 : 0);
        check({where, ".dir"},      dir,      m_dir);
        check({where, ".q_down"},   q_down,   m_qd);
        check({where, ".q_up"},     q_up,     m_qu);
        check({where, ".overflow"}, overflow, m_ovf);
    endtask

    task automatic step(input bit rd, input bit ru, input bit ack, input bit pd, input bit fc);
        req_down     = rd;
        req_up       = ru;
        lock_ack     = ack;
        passage_done = pd;
        fault_clr    = fc;
        @(posedge clk);
        model_step(rd, ru, ack, pd, fc);
        #1;
        compare_all("step");
        req_down     = 1'b0;
        req_up       = 1'b0;
        lock_ack     = 1'b0;
        passage_done = 1'b0;
        fault_clr    = 1'b0;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic apply_reset();
        reset = 1'b0;
        model_reset();
        #1;
        compare_all("reset");
        #3;
        reset = 1'b1;
    endtask

    // Wait (bounded) for the arrival request, log its direction, then accept
    // and complete the passage.
    task automatic serve();
        for (int i = 0; i < 20 && !arr_sw; i++) step(0, 0, 0, 0, 0);
        check("serve_wait_arr_sw", arr_sw, 1);
        dispatch_log.push_back(int'(dir));
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (q_down != 0 || q_up != 0); i++) serve();
        check("drain_q_down", q_down, 0);
        check("drain_q_up", q_up, 0);
    endtask

    initial begin
        int exp_order[6];
        n_checks     = 0;
        n_fail       = 0;
        req_down     = 1'b0;
        req_up       = 1'b0;
        lock_ack     = 1'b0;
        passage_done = 1'b0;
        fault_clr    = 1'b0;
        reset        = 1'b1;
        model_reset();
        #2;
        apply_reset();

        // Single passage on dir 0
        step(1, 0, 0, 0, 0);
        check("single.q_down_after_req", q_down, 1);
        check("single.arr_sw_not_yet", arr_sw, 0);
        step(0, 0, 0, 0, 0);
        check("single.arr_sw_up", arr_sw, 1);
        check("single.dir", dir, 0);
        step(0, 0, 1, 0, 0);
        check("single.q_down_dequeued", q_down, 0);
        check("single.arr_sw_drop", arr_sw, 0);
        check("single.busy_transit", busy, 1);
        step(0, 0, 0, 1, 0);
        check("single.busy_done", busy, 0);
        step(0, 0, 0, 0, 0);

        // Alternation from a fresh reset (dir 0 wins the first tie)
        apply_reset();
        dispatch_log.delete();
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        drain();
        exp_order = '{0, 1, 0, 1, 0, 1};
        check("alt.count", dispatch_log.size(), 6);
        for (int i = 0; i < 6 && i < dispatch_log.size(); i++)
            check($sformatf("alt.order[%0d]", i), dispatch_log[i], exp_order[i]);

        // Simultaneous request and dequeue on a full dir-0 queue
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !arr_sw; i++) step(0, 0, 0, 0, 0);
        check("simul.q_down_full", q_down, 4);
        check("simul.dir", dir, 0);
        step(1, 0, 1, 0, 0);
        check("simul.q_down_held", q_down, 4);
        check("simul.overflow_clear", overflow, 0);
        step(0, 0, 0, 1, 0);
        drain();

        // Overflow with the lock stalled in REQ
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("ovf.stalled_req", arr_sw, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0);
        check("ovf.q_up_sat", q_up, 4);
        check("ovf.flag", overflow, 1);
        drain();
        check("ovf.sticky", overflow, 1);

        // Timeout: fault exactly TIMEOUT cycles after entering TRANSIT
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !arr_sw; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int k = 1; k <= TIMEOUT; k++) begin
            step(0, 0, 0, 0, 0);
            if (k == TIMEOUT - 1) check("tmo.not_yet", fault, 0);
        end
        check("tmo.fault", fault, 1);
        check("tmo.busy_low", busy, 0);
        step(0, 1, 0, 0, 0);
        check("tmo.q_up_in_fault", q_up, 1);
        step(0, 0, 0, 0, 1);
        check("tmo.cleared", fault, 0);
        step(0, 0, 0, 0, 0);
        check("tmo.next_dispatch", arr_sw, 1);
        check("tmo.next_dir", dir, 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);

        // Reset mid-TRANSIT with two boats still queued
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20 && !arr_sw; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("rst.q_down_before", q_down, 2);
        check("rst.busy_before", busy, 1);
        apply_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 999) == 0) begin
                @(negedge clk);
                apply_reset();
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
